// File: rtl/mem_access_stage.sv
// Memory-access stage: drives a req/ack data-memory port for loads and stores,
// formats load data and emits one registered writeback beat per accepted op.
module mem_access_stage #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] store_data,
   input  logic [3:0]      mem_op,
   input  logic [4:0]      rd_idx,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_err
);

   localparam logic [3:0] OP_NONE = 4'b0000;
   localparam logic [3:0] OP_LB   = 4'b0001;
   localparam logic [3:0] OP_LH   = 4'b0010;
   localparam logic [3:0] OP_LW   = 4'b0011;
   localparam logic [3:0] OP_LBU  = 4'b0100;
   localparam logic [3:0] OP_LHU  = 4'b0101;
   localparam logic [3:0] OP_SB   = 4'b1000;
   localparam logic [3:0] OP_SH   = 4'b1001;
   localparam logic [3:0] OP_SW   = 4'b1010;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t          state_q;
   logic [7:0]      cnt_q;
   logic [3:0]      op_q;
   logic [XLEN-1:0] addr_q;
   logic [4:0]      rd_q;

   logic            req_q, we_q;
   logic [XLEN-1:0] daddr_q, wdata_q;
   logic [3:0]      be_q;
   logic            wb_valid_q, wb_err_q;
   logic [XLEN-1:0] wb_data_q;
   logic [4:0]      wb_rd_q;

   logic            legal_d, misalign_d, store_d;
   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d;
   logic [7:0]      lane_byte;
   logic [15:0]     lane_half;
   logic [XLEN-1:0] load_d;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      legal_d    = 1'b1;
      misalign_d = 1'b0;
      store_d    = 1'b0;
      be_d       = 4'b1111;
      wdata_d    = store_data;
      case (mem_op)
         OP_NONE, OP_LB, OP_LBU: ;
         OP_LH, OP_LHU: misalign_d = alu_result[0];
         OP_LW:         misalign_d = |alu_result[1:0];
         OP_SB: begin
            store_d = 1'b1;
            be_d    = 4'b0001 << alu_result[1:0];
            wdata_d = {(XLEN/8){store_data[7:0]}};
         end
         OP_SH: begin
            store_d    = 1'b1;
            misalign_d = alu_result[0];
            be_d       = alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_d    = {(XLEN/16){store_data[15:0]}};
         end
         OP_SW: begin
            store_d    = 1'b1;
            misalign_d = |alu_result[1:0];
         end
         default: legal_d = 1'b0;
      endcase
   end

   always_comb begin
      lane_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_half = dmem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (op_q)
         OP_LB:   load_d = {{(XLEN-8){lane_byte[7]}}, lane_byte};
         OP_LBU:  load_d = {{(XLEN-8){1'b0}}, lane_byte};
         OP_LH:   load_d = {{(XLEN-16){lane_half[15]}}, lane_half};
         OP_LHU:  load_d = {{(XLEN-16){1'b0}}, lane_half};
         default: load_d = dmem_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= OP_NONE;
         addr_q     <= '0;
         rd_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         daddr_q    <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_err_q   <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (ex_valid) begin
               op_q   <= mem_op;
               addr_q <= alu_result;
               rd_q   <= rd_idx;
               if (!legal_d || misalign_d) begin
                  state_q    <= RESP;
                  wb_valid_q <= 1'b1;
                  wb_err_q   <= 1'b1;
                  wb_rd_q    <= '0;
                  wb_data_q  <= alu_result;
               end else if (mem_op == OP_NONE) begin
                  state_q    <= RESP;
                  wb_valid_q <= 1'b1;
                  wb_err_q   <= 1'b0;
                  wb_rd_q    <= rd_idx;
                  wb_data_q  <= alu_result;
               end else begin
                  state_q <= BUS;
                  cnt_q   <= '0;
                  req_q   <= 1'b1;
                  we_q    <= store_d;
                  daddr_q <= {alu_result[XLEN-1:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
               end
            end
            BUS: begin
               if (dmem_ack) begin
                  state_q    <= RESP;
                  req_q      <= 1'b0;
                  wb_valid_q <= 1'b1;
                  wb_err_q   <= 1'b0;
                  wb_rd_q    <= op_q[3] ? 5'd0 : rd_q;
                  wb_data_q  <= op_q[3] ? '0 : load_d;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                     state_q    <= RESP;
                     req_q      <= 1'b0;
                     wb_valid_q <= 1'b1;
                     wb_err_q   <= 1'b1;
                     wb_rd_q    <= '0;
                     wb_data_q  <= addr_q;
                  end
               end
            end
            RESP: begin
               state_q    <= IDLE;
               wb_valid_q <= 1'b0;
               wb_err_q   <= 1'b0;
               wb_rd_q    <= '0;
               wb_data_q  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ex_ready   = (state_q == IDLE);
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = daddr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;
   assign wb_valid   = wb_valid_q;
   assign wb_data    = wb_data_q;
   assign wb_rd      = wb_rd_q;
   assign wb_err     = wb_err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU. It consumes the ALU result as an effective address or pass-through value, together with store data and a memory-op code.
- Runs a request/acknowledge transaction on the data-memory port and formats load data: byte/half extraction, sign/zero extension.
- Presents one registered writeback beat per accepted operation.
- Stalls the execute side through a ready/valid handshake while a bus transaction is outstanding.

Parameters:
- XLEN, 32, data and address width.
- ACK_TIMEOUT, 255, maximum cycles spent waiting for dmem_ack before the access is aborted with an error. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents an operation.
- ex_ready  out  1  stage can accept an operation this cycle.
- alu_result  in  XLEN  ALU result; the effective address for load/store ops.
- store_data  in  XLEN  rs2 value for stores.
- mem_op  in  4  0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes are illegal.
- rd_idx  in  5  destination register.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word-aligned address (bits [1:0] = 0).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access completes this cycle; read data is valid with it.
- dmem_rdata  in  XLEN  read word.
- wb_valid  out  1  one-cycle writeback beat.
- wb_data  out  XLEN  result to write to the register file.
- wb_rd  out  5  destination register; forced to 0 for stores and errors.
- wb_err  out  1  misaligned, illegal-op or timeout, qualified by wb_valid.

Behaviour:
- Reset values: state IDLE, all outputs 0, ex_ready 1, timeout counter 0.
- Reset asserted mid-transaction drops dmem_req immediately. Any later dmem_ack is ignored.
- Accept occurs when ex_valid & ex_ready; all inputs are latched on that edge.
- ex_ready = (state == IDLE). There is no accept in the same cycle as wb_valid.
- States are IDLE, BUS, RESP.
- IDLE, mem_op = none:
  - go to RESP; the next cycle carries wb_valid=1, wb_data=alu_result, wb_rd=rd_idx.
  - Latency 1 cycle.
- IDLE, illegal op or misaligned access (half with addr[0]=1; word with addr[1:0]!=0):
  - go to RESP with wb_err=1, wb_rd=0, wb_data=alu_result (the faulting address).
  - No bus access is made.
- IDLE, legal aligned load/store:
  - go to BUS; dmem_req=1 from the next cycle, registered.
  - dmem_addr = {addr[XLEN-1:2], 2'b00}.
- Byte enables (stores only; 1111 for loads):
  - SB: 0001 shifted left by addr[1:0].
  - SH: 0011 shifted left by addr[1]*2.
  - SW: 1111.
- Store data: dmem_wdata = byte replicated x4 (SB), half x2 (SH), or the full word (SW).
- BUS:
  - dmem_req, we, addr, be and wdata are held stable until the ack cycle.
  - When dmem_ack=1, dmem_req drops on the next edge and the state goes to RESP.
  - An ack arriving in the first BUS cycle is legal; best-case memory latency is then 2 cycles.
- Load formatting, applied to dmem_rdata captured on the ack edge:
  - select the lane by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Store completion: wb_valid pulses with wb_rd=0 and wb_data=0.
- Timeout:
  - the counter increments each BUS cycle without ack.
  - When it reaches ACK_TIMEOUT, dmem_req is dropped and the state goes to RESP with wb_err=1 and wb_rd=0.
  - The counter clears on entry to BUS.
- RESP: wb_valid=1 for exactly one cycle, then IDLE. Outputs are registered.
- dmem_ack while not in BUS is ignored.

Test Plan:
- Reset, then ADD pass-through: alu_result=0x0000_1234, rd=5 -> wb_valid 1 cycle later, wb_data=0x1234, wb_rd=5, dmem_req never asserted.
- LB at 0x103, ack on first BUS cycle, rdata=0x80AA_BBCC -> dmem_addr=0x100, be=1111, wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH at 0x202, data=0xDEAD_BEEF, ack after 3 cycles -> be=1100, wdata=0xBEEF_BEEF, req held stable 3 cycles, wb_rd=0, ex_ready low throughout.
- LW at 0x101 -> no dmem_req, wb_err=1, wb_data=0x101; mem_op=0111 -> wb_err=1.
- ACK_TIMEOUT=4, LW with no ack -> req high exactly 4 cycles, then wb_err=1; a late ack is ignored and the next op is accepted normally.
- rst pulsed during BUS -> dmem_req=0 asynchronously, ex_ready=1 after release, no wb_valid emitted.
